// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// A conversion starts on start, or in AUTO mode whenever bin_in differs from the last captured value.
`timescale 1ns/1ps
module result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int AUTO   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [WIDTH-1:0]      last_bin_q, last_bin_d;
  logic [BW-1:0]         scratch_q, scratch_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  trigger;
  logic                  last_cnt;
  logic [BW-1:0]         corr;
  logic [BW+WIDTH-1:0]   cat;

  // Per-digit correction: digits >= 5 get +3 so the following doubling carries into the next digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign trigger  = start | ((AUTO != 0) && (bin_in != last_bin_q));
  assign last_cnt = (cnt_q == CW'(1));
  assign corr     = add3(scratch_q);
  assign cat      = {corr, shift_q} << 1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      last_bin_q <= '0;
      scratch_q  <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      last_bin_q <= last_bin_d;
      scratch_q  <= scratch_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    last_bin_d = last_bin_q;
    scratch_d  = scratch_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          shift_d    = bin_in;
          last_bin_d = bin_in;
          scratch_d  = '0;
          cnt_d      = CW'(WIDTH);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = cat[BW+WIDTH-1:WIDTH];
        shift_d   = cat[WIDTH-1:0];
        cnt_d     = cnt_q - CW'(1);
        if (last_cnt) begin
          bcd_d   = cat[BW+WIDTH-1:WIDTH];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    bcd_out = bcd_q;
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: one manual-start instance (AUTO=0) and one auto-trigger instance (AUTO=1).
`timescale 1ns/1ps
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  bin0 = 8'h00, bin1 = 8'h00;
  logic        busy0, done0, busy1, done1;
  logic [11:0] bcd0, bcd1;

  int vectors = 0;
  int miscompares = 0;
  int d0cnt = 0, d1cnt = 0;

  always #5 clk = ~clk;

  result_bcd_converter #(.WIDTH(8), .DIGITS(3), .AUTO(0)) u_man (
    .clk(clk), .resetn(resetn), .start(start0), .bin_in(bin0),
    .busy(busy0), .done(done0), .bcd_out(bcd0));

  result_bcd_converter #(.WIDTH(8), .DIGITS(3), .AUTO(1)) u_auto (
    .clk(clk), .resetn(resetn), .start(start1), .bin_in(bin1),
    .busy(busy1), .done(done1), .bcd_out(bcd1));

  always @(posedge clk) begin
    if (done0 === 1'b1) d0cnt <= d0cnt + 1;
    if (done1 === 1'b1) d1cnt <= d1cnt + 1;
  end

  // Reference: decimal digits computed directly with division.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Steps until the selected done is seen; n = edges taken, or -1 on timeout.
  task automatic wait_done(input bit which, input int budget, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if ((which ? done1 : done0) === 1'b1) return;
      if (n >= budget) begin n = -1; return; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    vectors++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || bcd0 !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_man: busy=%b done=%b bcd=%h, want 0 0 000", busy0, done0, bcd0);
    end
    repeat (4) step();
    vectors++;
    if (busy1 !== 1'b0 || d1cnt !== 0 || bcd1 !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_auto_zero: busy=%b dones=%0d bcd=%h, want 0 0 000", busy1, d1cnt, bcd1);
    end
  endtask

  task automatic test_max();
    start0 = 1'b1; bin0 = 8'hFF;
    step();
    start0 = 1'b0;
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL max_busy_k: busy=%b, want 1", busy0);
    end
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 7) begin
        vectors++;
        if (bcd0 !== 12'h000 || done0 !== 1'b0 || busy0 !== 1'b1) begin
          miscompares++;
          $display("FAIL max_k7: bcd=%h done=%b busy=%b, want 000 0 1", bcd0, done0, busy0);
        end
      end
      if (i == 8) begin
        vectors++;
        if (bcd0 !== 12'h255 || done0 !== 1'b1 || busy0 !== 1'b1) begin
          miscompares++;
          $display("FAIL max_k8: bcd=%h done=%b busy=%b, want 255 1 1", bcd0, done0, busy0);
        end
      end
      if (i == 9) begin
        vectors++;
        if (bcd0 !== 12'h255 || done0 !== 1'b0 || busy0 !== 1'b0) begin
          miscompares++;
          $display("FAIL max_k9: bcd=%h done=%b busy=%b, want 255 0 0", bcd0, done0, busy0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [3] = '{8'h00, 8'h2A, 8'h09};
    logic [11:0] exp  [3] = '{12'h000, 12'h042, 12'h009};
    int base, n, tprev, tnow;
    base = d0cnt;
    tprev = 0;
    tnow = 0;
    for (int j = 0; j < 3; j++) begin
      start0 = 1'b1; bin0 = vals[j];
      wait_done(1'b0, 30, n);
      start0 = 1'b0;
      tnow = tnow + n;
      vectors++;
      if (bcd0 !== exp[j] || (j > 0 && (tnow - tprev) != 10)) begin
        miscompares++;
        $display("FAIL b2b_%0d: bcd=%h spacing=%0d, want %h spacing 10", j, bcd0, tnow - tprev, exp[j]);
      end
      tprev = tnow;
      step();
      tnow++;
    end
    repeat (3) step();
    vectors++;
    if (d0cnt - base !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: dones=%0d, want 3", d0cnt - base);
    end
  endtask

  task automatic test_start_ignored();
    int base, n;
    base = d0cnt;
    start0 = 1'b1; bin0 = 8'h64;
    step();
    start0 = 1'b0;
    repeat (3) step();
    start0 = 1'b1; bin0 = 8'h05;
    step();
    start0 = 1'b0;
    wait_done(1'b0, 20, n);
    vectors++;
    if (n != 4 || bcd0 !== 12'h100) begin
      miscompares++;
      $display("FAIL ignore_result: bcd=%h edges=%0d, want 100 4", bcd0, n);
    end
    repeat (15) step();
    vectors++;
    if (d0cnt - base !== 1 || bcd0 !== 12'h100 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_after: dones=%0d bcd=%h busy=%b, want 1 100 0", d0cnt - base, bcd0, busy0);
    end
  endtask

  task automatic test_auto_chain();
    int base, n, a, b, c, x;
    a = 1; b = 2; c = 3; x = 4;
    base = d1cnt;
    bin1 = 8'(a * x * x + b * x + c);
    wait_done(1'b1, 20, n);
    vectors++;
    if (n != 9 || bcd1 !== 12'h027) begin
      miscompares++;
      $display("FAIL auto_chain: bcd=%h edges=%0d, want 027 9", bcd1, n);
    end
    repeat (20) step();
    vectors++;
    if (d1cnt - base !== 1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_chain_quiet: dones=%0d busy=%b, want 1 0", d1cnt - base, busy1);
    end
  endtask

  task automatic test_auto_change_busy();
    int base, n;
    base = d1cnt;
    bin1 = 8'h11;
    repeat (4) step();
    bin1 = 8'hC8;
    wait_done(1'b1, 20, n);
    vectors++;
    if (bcd1 !== 12'h017) begin
      miscompares++;
      $display("FAIL auto_first: bcd=%h, want 017", bcd1);
    end
    wait_done(1'b1, 20, n);
    vectors++;
    if (n != 10 || bcd1 !== 12'h200) begin
      miscompares++;
      $display("FAIL auto_second: bcd=%h edges=%0d, want 200 10", bcd1, n);
    end
    repeat (15) step();
    vectors++;
    if (d1cnt - base !== 2) begin
      miscompares++;
      $display("FAIL auto_count: dones=%0d, want 2", d1cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    base = d0cnt;
    start0 = 1'b1; bin0 = 8'h99;
    step();
    start0 = 1'b0;
    repeat (3) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    vectors++;
    if (bcd0 !== 12'h000 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state: bcd=%h busy=%b done=%b, want 000 0 0", bcd0, busy0, done0);
    end
    repeat (12) step();
    vectors++;
    if (d0cnt - base !== 0 || bcd0 !== 12'h000) begin
      miscompares++;
      $display("FAIL rstmid_nodone: dones=%0d bcd=%h, want 0 000", d0cnt - base, bcd0);
    end
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    wait_done(1'b0, 20, n);
    vectors++;
    if (n != 8 || bcd0 !== 12'h153) begin
      miscompares++;
      $display("FAIL rstmid_fresh: bcd=%h edges=%0d, want 153 8", bcd0, n);
    end
    step();
  endtask

  task automatic test_random();
    int n;
    logic [7:0] v;
    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      start0 = 1'b1; bin0 = v;
      wait_done(1'b0, 20, n);
      start0 = 1'b0;
      vectors++;
      if (n != 9 || bcd0 !== to_bcd(int'(v))) begin
        miscompares++;
        $display("FAIL rand_man_%0d: in=%h bcd=%h edges=%0d, want %h 9", i, v, bcd0, n, to_bcd(int'(v)));
      end
      step();
      v = 8'($urandom_range(0, 255));
      if (v == bin1) v = v ^ 8'h01;
      bin1 = v;
      wait_done(1'b1, 20, n);
      vectors++;
      if (n != 9 || bcd1 !== to_bcd(int'(v))) begin
        miscompares++;
        $display("FAIL rand_auto_%0d: in=%h bcd=%h edges=%0d, want %h 9", i, v, bcd1, n, to_bcd(int'(v)));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_start_ignored();
    test_auto_chain();
    test_auto_change_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the polynomial evaluator's 8-bit data_result register.
- Converts the unsigned result to decimal digits for the HEX display drivers, using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Conversion starts on an explicit start pulse, or automatically when the input value changes (AUTO mode), because data_result carries no valid strobe.

Parameters:
- WIDTH, 8, width of the unsigned binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; other combinations are unsupported.
- AUTO, 1, when 1 a change of bin_in versus the last captured value also triggers a conversion.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request to convert bin_in; sampled only in IDLE.
- bin_in  input  WIDTH  unsigned binary value; connects to the evaluator data_result.
- busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD; [3:0] is ones, [7:4] tens, [11:8] hundreds, and so on.

Behaviour:
- Reset (resetn=0 at a clk edge): state goes to IDLE; bcd_out, busy, done, the internal scratch/shift registers, bit counter and last_bin all become 0. Reset is honoured mid-conversion; the partial result is discarded and bcd_out is not updated.
- States:
  - IDLE: trigger = start | (AUTO & (bin_in != last_bin)). On a trigger edge:
    - bin_in is captured into the shift register and into last_bin.
    - The BCD scratch register is cleared.
    - The counter is set to WIDTH.
    - Next state is SHIFT.
    - With no trigger, stay in IDLE.
  - SHIFT: each cycle, two steps operate on the scratch register:
    - First, every 4-bit scratch digit >= 5 gets +3 (per-digit, no carry between digits).
    - Then the concatenation {scratch, shift} is shifted left by 1.
    - The counter decrements each cycle. The cycle that uses the last count loads bcd_out from the corrected, shifted scratch and moves to DONE. SHIFT lasts exactly WIDTH cycles.
  - DONE: done=1 and busy=1 for exactly one cycle; next state is IDLE unconditionally.
- Latency: a trigger sampled at edge k gives busy=1 from k through k+WIDTH+1. bcd_out holds the new value from edge k+WIDTH. done is high in the cycle after edge k+WIDTH. IDLE is re-entered at edge k+WIDTH+1. With WIDTH=8, start to done is 9 cycles.
- bcd_out holds its value between conversions and changes only at the load point.
- start while busy (SHIFT or DONE): ignored, not queued. bin_in changes while busy: ignored. In AUTO mode they are picked up on return to IDLE because last_bin differs.
- start and an AUTO change in the same cycle: one conversion only.
- After reset last_bin=0, so bin_in=0 causes no auto conversion; bcd_out is already 0.
- Arithmetic is unsigned only; no negative or overflow handling. The maximum input 2^WIDTH-1 must convert exactly.
- done and busy are registered outputs (decoded from state registers, no combinational path from inputs).

Test Plan:
- AUTO=0, bin_in=8'hFF, start pulse at edge k: busy=1 from k; bcd_out=12'h255 valid at k+8; done high exactly one cycle after edge k+8; busy=0 after k+9.
- AUTO=0, convert 8'h00, then 8'h2A, then 8'h09 back-to-back, with start asserted again on the first IDLE cycle each time: bcd_out = 12'h000, 12'h042, 12'h009; exactly three done pulses, spaced 10 cycles apart.
- AUTO=0, start 8'h64; during SHIFT pulse start with bin_in=8'h05: result is 12'h100, only one done pulse, and no second conversion afterwards.
- AUTO=1, evaluator chain A=1, B=2, C=3, x=4 with the result register changing 8'h00 -> 8'h1B and no start pulse: one auto conversion; bcd_out=12'h027, done pulses once, and there is no further conversion while bin_in stays at 8'h1B.
- AUTO=1, bin_in steps 8'h11 -> 8'hC8 during a conversion: the first result is 12'h017, then a second conversion gives 12'h200; two done pulses.
- Reset mid-conversion: start with 8'h99, assert resetn=0 for one edge at k+4: bcd_out=0, busy=0, done never pulses; IDLE resumes, and a fresh start with 8'h99 gives 12'h153.
